// File: rtl/clic_scan_arbiter.sv
// clic_scan_arbiter
//   Multi-cycle CLIC arbiter. Scans LANES sources per cycle over
//   N_SOURCE/LANES chunks and keeps a running best {key, id}, where
//   key = {mode, intctl}. The final winner is handed to the hart over a
//   valid/ready handshake. While a winner is presented, a shadow scan keeps
//   running. It raises a kill request if the presented source is preempted
//   by a strictly higher key, or if that source is withdrawn (ip&ie dropped).
// Ports:
//   clk_i, rst_i           clock, async active-high reset
//   ip_i, ie_i             pending / enable bit per source
//   intctl_i, mode_i       per-source level/priority and privilege mode
//   irq_valid_o/ready_i    winner handshake; irq_id/level/priv_o hold the winner
//   irq_kill_req_o/ack_i   withdrawal request / acknowledge
//   claim_o, claim_id_o    one-cycle pulse and ID on an accepted handshake
module clic_scan_arbiter #(
  parameter int N_SOURCE   = 256,
  parameter int INTCTLBITS = 8,
  parameter int LANES      = 16,
  parameter int SRC_W      = $clog2(N_SOURCE)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [N_SOURCE-1:0]            ip_i,
  input  logic [N_SOURCE-1:0]            ie_i,
  input  logic [N_SOURCE*INTCTLBITS-1:0] intctl_i,
  input  logic [N_SOURCE*2-1:0]          mode_i,
  output logic                           irq_valid_o,
  input  logic                           irq_ready_i,
  output logic [SRC_W-1:0]               irq_id_o,
  output logic [INTCTLBITS-1:0]          irq_level_o,
  output logic [1:0]                     irq_priv_o,
  output logic                           irq_kill_req_o,
  input  logic                           irq_kill_ack_i,
  output logic                           claim_o,
  output logic [SRC_W-1:0]               claim_id_o
);
  localparam int NCHUNK = N_SOURCE / LANES;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int KEY_W  = 2 + INTCTLBITS;
  localparam int CW     = KEY_W + SRC_W;   // {mode, intctl, id}

  typedef enum logic {SCAN, PRESENT} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    found_q, found_d;
  logic [CW-1:0]           best_q, best_d;
  logic                    valid_q, valid_d;
  logic [SRC_W-1:0]        id_q, id_d;
  logic [INTCTLBITS-1:0]   level_q, level_d;
  logic [1:0]              priv_q, priv_d;
  logic                    kill_q, kill_d;
  logic                    claim_q, claim_d;
  logic [SRC_W-1:0]        claim_id_q, claim_id_d;

  logic [LANES-1:0]            lane_cand;
  logic [LANES-1:0][CW-1:0]    lane_val;
  logic [LANES-1:0][SRC_W-1:0] lane_idx;

  // The chunk's source index is {chunk, lane} because LANES is a power of two.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_idx[l]  = {cnt_q, LANE_W'(l)};
    assign lane_cand[l] = ip_i[lane_idx[l]] & ie_i[lane_idx[l]];
    assign lane_val[l]  = {mode_i[lane_idx[l]*2 +: 2],
                           intctl_i[lane_idx[l]*INTCTLBITS +: INTCTLBITS],
                           lane_idx[l]};
  end

  // Comparing {key, id} as one unsigned value breaks ties toward higher ID.
  logic          chunk_found, m_found, last, pres_live;
  logic [CW-1:0] chunk_best, m_best;

  always_comb begin
    chunk_found = 1'b0;
    chunk_best  = '0;
    for (int l = 0; l < LANES; l++) begin
      if (lane_cand[l] && (!chunk_found || lane_val[l] > chunk_best)) begin
        chunk_found = 1'b1;
        chunk_best  = lane_val[l];
      end
    end
    m_found   = found_q | chunk_found;
    m_best    = (chunk_found && (!found_q || chunk_best > best_q)) ? chunk_best : best_q;
    last      = (cnt_q == CNT_W'(NCHUNK - 1));
    pres_live = ip_i[id_q] & ie_i[id_q];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = last ? '0 : cnt_q + CNT_W'(1);
    found_d    = last ? 1'b0 : m_found;
    best_d     = last ? '0 : m_best;
    valid_d    = valid_q;
    id_d       = id_q;
    level_d    = level_q;
    priv_d     = priv_q;
    kill_d     = kill_q;
    claim_d    = 1'b0;
    claim_id_d = claim_id_q;
    case (state_q)
      SCAN: begin
        if (last && m_found) begin
          state_d = PRESENT;
          valid_d = 1'b1;
          id_d    = m_best[SRC_W-1:0];
          level_d = m_best[SRC_W +: INTCTLBITS];
          priv_d  = m_best[CW-1 -: 2];
        end
      end
      PRESENT: begin
        if (irq_ready_i) begin
          // Handshake beats a simultaneous kill acknowledge.
          state_d    = SCAN;
          valid_d    = 1'b0;
          kill_d     = 1'b0;
          claim_d    = 1'b1;
          claim_id_d = id_q;
          cnt_d      = '0;
          found_d    = 1'b0;
          best_d     = '0;
        end else if (kill_q && irq_kill_ack_i) begin
          state_d = SCAN;
          valid_d = 1'b0;
          kill_d  = 1'b0;
          cnt_d   = '0;
          found_d = 1'b0;
          best_d  = '0;
        end else if (!pres_live ||
                     (last && m_found && m_best[CW-1 -: KEY_W] > {priv_q, level_q})) begin
          kill_d = 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= SCAN;
      cnt_q      <= '0;
      found_q    <= 1'b0;
      best_q     <= '0;
      valid_q    <= 1'b0;
      id_q       <= '0;
      level_q    <= '0;
      priv_q     <= '0;
      kill_q     <= 1'b0;
      claim_q    <= 1'b0;
      claim_id_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      found_q    <= found_d;
      best_q     <= best_d;
      valid_q    <= valid_d;
      id_q       <= id_d;
      level_q    <= level_d;
      priv_q     <= priv_d;
      kill_q     <= kill_d;
      claim_q    <= claim_d;
      claim_id_q <= claim_id_d;
    end
  end

  assign irq_valid_o    = valid_q;
  assign irq_id_o       = id_q;
  assign irq_level_o    = level_q;
  assign irq_priv_o     = priv_q;
  assign irq_kill_req_o = kill_q;
  assign claim_o        = claim_q;
  assign claim_id_o     = claim_id_q;
endmodule

// File: tb/tb_clic_scan_arbiter.sv
module tb_clic_scan_arbiter;
  localparam int N = 256, IB = 8;

  logic          clk_i = 0, rst_i = 1;
  logic [N-1:0]  ip_i = '0, ie_i = '0;
  logic [N*IB-1:0] intctl_i = '0;
  logic [N*2-1:0]  mode_i = '0;
  logic          irq_ready_i = 0, irq_kill_ack_i = 0;
  logic          irq_valid_o, irq_kill_req_o, claim_o;
  logic [7:0]    irq_id_o, claim_id_o, irq_level_o;
  logic [1:0]    irq_priv_o;

  int checks = 0, failures = 0;

  clic_scan_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i), .ip_i(ip_i), .ie_i(ie_i),
    .intctl_i(intctl_i), .mode_i(mode_i),
    .irq_valid_o(irq_valid_o), .irq_ready_i(irq_ready_i),
    .irq_id_o(irq_id_o), .irq_level_o(irq_level_o), .irq_priv_o(irq_priv_o),
    .irq_kill_req_o(irq_kill_req_o), .irq_kill_ack_i(irq_kill_ack_i),
    .claim_o(claim_o), .claim_id_o(claim_id_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_src(input int i, input bit p, input bit e, input int ctl, input int md);
    ip_i[i] = p;
    ie_i[i] = e;
    intctl_i[i*IB +: IB] = 8'(ctl);
    mode_i[i*2 +: 2] = 2'(md);
  endtask

  task automatic clear_all();
    ip_i = '0; ie_i = '0; intctl_i = '0; mode_i = '0;
  endtask

  task automatic rand_fill();
    int md;
    for (int i = 0; i < N; i++) begin
      md = int'($urandom % 3);
      if (md == 2) md = 3;
      set_src(i, ($urandom % 8) == 0, ($urandom % 4) != 0, int'($urandom % 256), md);
    end
  endtask

  // Reference: the pending+enabled source with the largest mode*256+intctl,
  // ties going to the larger index.
  task automatic model_win(output bit f, output int id);
    int bk, k;
    f = 0; id = 0; bk = -1;
    for (int i = 0; i < N; i++) begin
      if (ip_i[i] && ie_i[i]) begin
        k = int'(mode_i[i*2 +: 2]) * 256 + int'(intctl_i[i*IB +: IB]);
        if (k > bk || (k == bk && i > id)) begin
          bk = k; id = i; f = 1;
        end
      end
    end
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_valid"}, irq_valid_o, 0);
    chk({tag, "_kill"},  irq_kill_req_o, 0);
    chk({tag, "_claim"}, claim_o, 0);
    chk({tag, "_id"},    irq_id_o, 0);
  endtask

  task automatic do_reset();
    rst_i = 1;
    #1;
    chk_outs_zero("reset");
    tick();
    rst_i = 0;
  endtask

  // Waits for the model's winner to be presented, or confirms silence.
  task automatic wait_valid(input string tag, output bit f, output int id);
    bit seen;
    model_win(f, id);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (irq_valid_o) begin seen = 1; break; end
      tick();
    end
    chk({tag, "_valid"}, seen, f);
    if (f && seen) begin
      chk({tag, "_id"},    irq_id_o, id);
      chk({tag, "_level"}, irq_level_o, intctl_i[id*IB +: IB]);
      chk({tag, "_priv"},  irq_priv_o, mode_i[id*2 +: 2]);
    end
  endtask

  task automatic handshake(input string tag, input int id);
    irq_ready_i = 1;
    ip_i[id] = 0;          // a claimed source stops pending
    tick();
    irq_ready_i = 0;
    chk({tag, "_claim"},   claim_o, 1);
    chk({tag, "_claimid"}, claim_id_o, id);
    chk({tag, "_vdrop"},   irq_valid_o, 0);
    tick();
    chk({tag, "_pulse"},   claim_o, 0);
  endtask

  task automatic wait_kill(input string tag);
    bit seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (irq_kill_req_o) begin seen = 1; break; end
      tick();
    end
    chk({tag, "_kill"}, seen, 1);
  endtask

  initial begin
    bit f, any;
    int id, s, lvl, pv, act;

    // Directed: reset state, lone source 5.
    clear_all();
    do_reset();
    set_src(5, 1, 1, 8'h40, 3);
    wait_valid("src5", f, id);
    irq_kill_ack_i = 1;     // no kill pending: must be ignored
    tick();
    irq_kill_ack_i = 0;
    chk("ack_ignored", irq_valid_o, 1);
    handshake("src5", 5);

    // Tie goes to the higher ID; mode outranks intctl.
    clear_all();
    set_src(17, 1, 1, 8'h80, 3);
    set_src(200, 1, 1, 8'h80, 3);
    do_reset();
    wait_valid("tie", f, id);
    clear_all();
    set_src(17, 1, 1, 8'hFF, 3);
    set_src(200, 1, 1, 8'hFF, 1);
    do_reset();
    wait_valid("mode", f, id);

    // Preemption by source 255, then kill ack.
    clear_all();
    set_src(3, 1, 1, 8'h10, 3);
    do_reset();
    wait_valid("pre3", f, id);
    set_src(255, 1, 1, 8'hF0, 3);
    wait_kill("pre255");
    irq_kill_ack_i = 1;
    tick();
    irq_kill_ack_i = 0;
    chk("pre_vdrop", irq_valid_o, 0);
    chk("pre_noclaim", claim_o, 0);
    wait_valid("pre255", f, id);

    // Withdrawal of 9 with ready+ack together: handshake wins.
    clear_all();
    set_src(9, 1, 1, 8'h22, 1);
    do_reset();
    wait_valid("wd9", f, id);
    ie_i[9] = 0;
    tick();
    chk("wd9_kill", irq_kill_req_o, 1);
    irq_ready_i = 1; irq_kill_ack_i = 1;
    tick();
    irq_ready_i = 0; irq_kill_ack_i = 0;
    chk("wd9_claim", claim_o, 1);
    chk("wd9_claimid", claim_id_o, 9);
    chk("wd9_kdrop", irq_kill_req_o, 0);

    // No candidates for 100 cycles.
    clear_all();
    do_reset();
    any = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      any |= irq_valid_o | irq_kill_req_o | claim_o;
    end
    chk("idle100", any, 0);

    // Async reset mid-scan and mid-PRESENT.
    set_src(130, 1, 1, 8'h55, 0);
    repeat (7) tick();
    do_reset();
    wait_valid("rst_scan", f, id);
    tick();
    do_reset();
    wait_valid("rst_pres", f, id);

    // Randomized transactions against the reference model.
    rand_fill();
    do_reset();
    for (int it = 0; it < 60; it++) begin
      wait_valid("rnd", f, id);
      if (!f) begin
        rand_fill();
        do_reset();
        continue;
      end
      lvl = int'(intctl_i[id*IB +: IB]);
      pv  = int'(mode_i[id*2 +: 2]);
      act = int'($urandom % 3);
      if (act == 1 && pv == 3 && lvl == 255) act = 0;
      case (act)
        0: handshake("rnd_hs", id);
        1: begin
          s = int'($urandom % N);
          if (s == id) s = (s + 1) % N;
          set_src(s, 1, 1, (pv < 3) ? int'($urandom % 256)
                                    : lvl + 1 + int'($urandom % (255 - lvl)), 3);
          wait_kill("rnd_pre");
          irq_kill_ack_i = 1;
          tick();
          irq_kill_ack_i = 0;
          chk("rnd_pre_vdrop", irq_valid_o, 0);
          chk("rnd_pre_noclaim", claim_o, 0);
        end
        default: begin
          ie_i[id] = 0;
          tick();
          chk("rnd_wd_kill", irq_kill_req_o, 1);
          irq_kill_ack_i = 1;
          irq_ready_i = $urandom % 2;
          tick();
          chk("rnd_wd_claim", claim_o, irq_ready_i);
          if (irq_ready_i) chk("rnd_wd_claimid", claim_id_o, id);
          chk("rnd_wd_kdrop", irq_kill_req_o, 0);
          chk("rnd_wd_vdrop", irq_valid_o, 0);
          irq_kill_ack_i = 0;
          irq_ready_i = 0;
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
